// File: rtl/elevator_stop_queue.sv
// elevator_stop_queue: ordered stop queue for the elevator manager datapath.
// Each accepted (origin, destination) request is placed by a scan FSM that
// walks the queue one entry per cycle, slotting a stop in wherever the car
// already passes that floor, dropping stops that are already queued, and
// otherwise appending. Entry 0 is always the next stop for the control unit.
module elevator_stop_queue #(
    parameter int FLOOR_W = 4,
    parameter int DEPTH   = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [FLOOR_W-1:0]         req_origin,
    input  logic [FLOOR_W-1:0]         req_dest,
    input  logic [FLOOR_W-1:0]         current_floor,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [FLOOR_W-1:0]         head_floor,
    output logic                       going_up,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       busy,
    output logic                       merged,
    output logic                       dup_drop
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    // A request may add two stops, so it is only taken with two free slots.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN_O, SCAN_D, DONE} scanState_t;

    scanState_t         state, stateNext;
    logic [FLOOR_W-1:0] q     [DEPTH];
    logic [FLOOR_W-1:0] qNext [DEPTH];
    logic [CNT_W-1:0]   cnt, cntNext;
    logic [CNT_W-1:0]   idx, idxNext;
    logic [FLOOR_W-1:0] originReg, originNext;
    logic [FLOOR_W-1:0] destReg, destNext;
    logic               pendingPop, pendingNext;
    logic               mergedReg, mergedNext;
    logic               dupReg, dupNext;

    logic [FLOOR_W-1:0] curEntry, prevEntry, scanVal;
    logic               atEnd, isDup, isBetween, readyInt, doPop;

    // Pick the entry under the scan pointer and the stop just before it
    // (the car's own floor stands in for the stop before entry 0).
    // NOTE: combinational blocks use blocking '=' so later statements see earlier results.
    always_comb begin
        curEntry  = '0;
        prevEntry = current_floor;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == idx)     curEntry  = q[i];
            if (CNT_W'(i + 1) == idx) prevEntry = q[i];
        end
    end

    assign scanVal   = (state == SCAN_O) ? originReg : destReg;
    assign atEnd     = (idx == cnt);
    assign isDup     = !atEnd && (curEntry == scanVal);
    // Stop lies strictly between the previous stop and this one, in either
    // travel direction, so the car passes it on the way: serve it en route.
    assign isBetween = !atEnd &&
                       (((prevEntry < scanVal) && (scanVal < curEntry)) ||
                        ((curEntry < scanVal) && (scanVal < prevEntry)));
    assign readyInt  = (state == IDLE) && (cnt <= READY_MAX);
    assign doPop     = (pop || pendingPop) && (cnt != '0);

    // Next-state, queue update and pulse generation for the scan FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        stateNext   = state;
        qNext       = q;
        cntNext     = cnt;
        idxNext     = idx;
        originNext  = originReg;
        destNext    = destReg;
        pendingNext = pendingPop;
        mergedNext  = 1'b0;
        dupNext     = 1'b0;

        case (state)
            IDLE: begin
                // A pop deferred during the scan is served here; it merges
                // with any pop arriving in this same cycle.
                pendingNext = 1'b0;
                if (doPop) begin
                    for (int i = 0; i < DEPTH - 1; i++) qNext[i] = q[i + 1];
                    qNext[DEPTH-1] = '0;
                    cntNext = cnt - 1'b1;
                end
                // Readiness uses the pre-pop count; the scan sees the post-pop queue.
                if (req_valid && readyInt) begin
                    originNext = req_origin;
                    destNext   = req_dest;
                    idxNext    = '0;
                    stateNext  = SCAN_O;
                end
            end

            SCAN_O, SCAN_D: begin
                if (pop) pendingNext = 1'b1;
                if ((state == SCAN_D) && (destReg == originReg)) begin
                    dupNext   = 1'b1;
                    stateNext = DONE;
                end else if (atEnd || isBetween) begin
                    // Append and mid-queue insert are the same operation:
                    // slots above idx move up one, slots past count are zero.
                    if (idx == '0) qNext[0] = scanVal;
                    for (int i = 1; i < DEPTH; i++) begin
                        if (CNT_W'(i) == idx)     qNext[i] = scanVal;
                        else if (CNT_W'(i) > idx) qNext[i] = q[i - 1];
                    end
                    cntNext    = cnt + 1'b1;
                    mergedNext = (state == SCAN_O) && !atEnd;
                    idxNext    = idx + 1'b1;
                    stateNext  = (state == SCAN_O) ? SCAN_D : DONE;
                end else if (isDup) begin
                    dupNext   = 1'b1;
                    idxNext   = idx + 1'b1;
                    stateNext = (state == SCAN_O) ? SCAN_D : DONE;
                end else begin
                    idxNext = idx + 1'b1;
                end
            end

            DONE: begin
                if (pop) pendingNext = 1'b1;
                stateNext = IDLE;
            end

            default: stateNext = IDLE;
        endcase
    end

    // State, queue storage and pulse registers.
    // NOTE: the entries themselves are reset, because slots past count must read as zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            originReg  <= '0;
            destReg    <= '0;
            pendingPop <= 1'b0;
            mergedReg  <= 1'b0;
            dupReg     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so all registers update together.
            state      <= stateNext;
            cnt        <= cntNext;
            idx        <= idxNext;
            originReg  <= originNext;
            destReg    <= destNext;
            pendingPop <= pendingNext;
            mergedReg  <= mergedNext;
            dupReg     <= dupNext;
            q          <= qNext;
        end
    end

    assign req_ready  = readyInt;
    assign head_valid = (cnt != '0);
    assign head_floor = q[0];
    assign going_up   = head_valid && (q[0] > current_floor);
    assign count      = cnt;
    assign full       = (cnt == FULL_CNT);
    assign empty      = (cnt == '0);
    assign busy       = (state != IDLE);
    assign merged     = mergedReg;
    assign dup_drop   = dupReg;

endmodule
